// File: rtl/seg_pkg.sv
// ----------------------------------------------------------------------------
// seg_pkg : shared types and constants for the 6-digit segment scanner
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package seg_pkg;

   localparam int          NUM_DIG   = 6;
   localparam logic [7:0]  SEG_BLANK = 8'hff;
   localparam logic [5:0]  SEL_NONE  = 6'h3f;

   // Active-low g..a codes for 0..F, bit7 (dp) held off; entry 15 first.
   localparam logic [15:0][7:0] SEG_TABLE = {
      8'h8e, 8'h86, 8'ha1, 8'hc6, 8'h83, 8'h88, 8'h90, 8'h80,
      8'hf8, 8'h82, 8'h92, 8'h99, 8'hb0, 8'ha4, 8'hf9, 8'hc0
   };

   typedef struct packed {
      logic [3:0] val;
      logic       dp;
   } digit_t;

   typedef enum logic [0:0] {
      ST_BLANK = 1'b0,
      ST_SHOW  = 1'b1
   } scan_state_t;

endpackage

`default_nettype wire

// File: rtl/seg_scan_ctrl_if.sv
// ----------------------------------------------------------------------------
// seg_scan_ctrl_if : producer write port, commit control and display bus
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface seg_scan_ctrl_if;
   import seg_pkg::*;

   logic               wr_vld;
   logic               wr_rdy;
   logic [2:0]         wr_addr;
   logic [3:0]         wr_data;
   logic               wr_dp;
   logic               commit;
   logic               lzb;
   logic               commit_pend;
   logic               frame_done;
   logic [NUM_DIG-1:0] seg_sel;
   logic [7:0]         seg_ment;

   modport master (
      output wr_vld, wr_addr, wr_data, wr_dp, commit, lzb,
      input  wr_rdy, commit_pend, frame_done, seg_sel, seg_ment
   );

   modport slave (
      input  wr_vld, wr_addr, wr_data, wr_dp, commit, lzb,
      output wr_rdy, commit_pend, frame_done, seg_sel, seg_ment
   );

endinterface

`default_nettype wire

// File: rtl/seg_hex_dec.sv
// ----------------------------------------------------------------------------
// seg_hex_dec : hex digit + dp to active-low segment code, with blanking
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module seg_hex_dec
   import seg_pkg::*;
(
   input  logic [3:0] i_val,
   input  logic       i_dp,
   input  logic       i_blank,
   output logic [7:0] o_seg
);

   always_comb begin
      o_seg = SEG_BLANK;
      if (!i_blank) begin
         o_seg = SEG_TABLE[i_val];
         if (i_dp) begin
            o_seg[7] = 1'b0;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
// ----------------------------------------------------------------------------
// seg_scan_ctrl : 6-digit multiplexed display scanner, double-buffered store
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter int DIG_CYC   = 50_000,
   parameter int BLANK_CYC = 500
)(
   input  logic           clk,
   input  logic           rst,
   seg_scan_ctrl_if.slave bus
);

   localparam int            CW           = $clog2(DIG_CYC);
   localparam logic [CW-1:0] C_CNT_LAST   = CW'(DIG_CYC - 1);
   localparam logic [CW-1:0] C_BLANK_LAST = CW'(BLANK_CYC - 1);
   localparam logic [2:0]    C_DIG_LAST   = 3'(NUM_DIG - 1);

   logic [CW-1:0]      r_cnt0;
   logic [2:0]         r_cnt1;
   scan_state_t        r_state;
   scan_state_t        w_state_nxt;
   digit_t             r_shadow [NUM_DIG];
   digit_t             r_active [NUM_DIG];
   logic               r_commit_pend;
   logic               r_frame_done;
   logic [NUM_DIG-1:0] r_seg_sel;
   logic [7:0]         r_seg_ment;

   logic               w_cnt0_wrap;
   logic               w_boundary;
   logic               w_wr_fire;
   logic [NUM_DIG-1:0] w_lead;
   digit_t             w_cur;
   logic [7:0]         w_dec_seg;
   logic [NUM_DIG-1:0] w_sel_nxt;
   logic [7:0]         w_ment_nxt;

   assign w_cnt0_wrap = (r_cnt0 == C_CNT_LAST);
   assign w_boundary  = w_cnt0_wrap && (r_cnt1 == C_DIG_LAST);
   assign w_wr_fire   = bus.wr_vld && !r_commit_pend;
   assign w_cur       = r_active[r_cnt1];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt0 <= '0;
         r_cnt1 <= '0;
      end else begin
         r_cnt0 <= w_cnt0_wrap ? '0 : r_cnt0 + CW'(1);
         if (w_cnt0_wrap) begin
            r_cnt1 <= (r_cnt1 == C_DIG_LAST) ? 3'd0 : r_cnt1 + 3'd1;
         end
      end
   end

   // A digit is a leading zero if it and every digit above it is 0 without dp.
   always_comb begin
      logic v_run;
      v_run  = 1'b1;
      w_lead = '0;
      for (int d = NUM_DIG - 1; d >= 1; d--) begin
         v_run     = v_run && (r_active[d].val == 4'h0) && !r_active[d].dp;
         w_lead[d] = v_run;
      end
   end

   seg_hex_dec u_dec (
      .i_val   (w_cur.val),
      .i_dp    (w_cur.dp),
      .i_blank (bus.lzb && w_lead[r_cnt1]),
      .o_seg   (w_dec_seg)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_BLANK;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_sel_nxt   = SEL_NONE;
      w_ment_nxt  = SEG_BLANK;
      case (r_state)
         ST_BLANK: begin
            if (r_cnt0 == C_BLANK_LAST) begin
               w_state_nxt = ST_SHOW;
            end
         end
         ST_SHOW: begin
            w_sel_nxt  = ~(NUM_DIG'(1) << r_cnt1);
            w_ment_nxt = w_dec_seg;
            if (w_cnt0_wrap) begin
               w_state_nxt = ST_BLANK;
            end
         end
         default: w_state_nxt = ST_BLANK;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_seg_sel    <= SEL_NONE;
         r_seg_ment   <= SEG_BLANK;
         r_frame_done <= 1'b0;
      end else begin
         r_seg_sel    <= w_sel_nxt;
         r_seg_ment   <= w_ment_nxt;
         r_frame_done <= w_boundary;
      end
   end

   // The copy only happens while pending, when writes are stalled, so the
   // published bank is always a complete snapshot.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int d = 0; d < NUM_DIG; d++) begin
            r_shadow[d] <= '0;
            r_active[d] <= '0;
         end
         r_commit_pend <= 1'b0;
      end else begin
         for (int d = 0; d < NUM_DIG; d++) begin
            if (w_wr_fire && (bus.wr_addr == 3'(d))) begin
               r_shadow[d] <= '{val: bus.wr_data, dp: bus.wr_dp};
            end
         end
         if (w_boundary && r_commit_pend) begin
            for (int d = 0; d < NUM_DIG; d++) begin
               r_active[d] <= r_shadow[d];
            end
            r_commit_pend <= 1'b0;
         end else if (bus.commit) begin
            r_commit_pend <= 1'b1;
         end
      end
   end

   assign bus.wr_rdy      = !r_commit_pend;
   assign bus.commit_pend = r_commit_pend;
   assign bus.frame_done  = r_frame_done;
   assign bus.seg_sel     = r_seg_sel;
   assign bus.seg_ment    = r_seg_ment;

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
// ----------------------------------------------------------------------------
// tb_seg_scan_ctrl : directed + random bench against a frame-position model
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_seg_scan_ctrl;

   localparam int DIG   = 8;
   localparam int BLK   = 2;
   localparam int FRAME = 6 * DIG;

   localparam logic [7:0] HEX [16] = '{
      8'hc0, 8'hf9, 8'ha4, 8'hb0, 8'h99, 8'h92, 8'h82, 8'hf8,
      8'h80, 8'h90, 8'h88, 8'h83, 8'hc6, 8'ha1, 8'h86, 8'h8e
   };

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   seg_scan_ctrl_if u_if ();

   seg_scan_ctrl #(
      .DIG_CYC   (DIG),
      .BLANK_CYC (BLK)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (u_if.slave)
   );

   logic [3:0] m_sh_val [6];
   logic       m_sh_dp  [6];
   logic [3:0] m_ac_val [6];
   logic       m_ac_dp  [6];
   bit         m_pend;
   int         m_pos;
   int         errors = 0;
   int         checks = 0;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] exp_ment(input int dig, input bit lzb);
      bit         blank;
      logic [7:0] code;
      blank = lzb && (dig > 0);
      for (int k = 5; k >= dig; k--) begin
         if (m_ac_val[k] != 4'h0 || m_ac_dp[k]) blank = 1'b0;
      end
      if (blank) return 8'hff;
      code = HEX[m_ac_val[dig]];
      if (m_ac_dp[dig]) code[7] = 1'b0;
      return code;
   endfunction

   // One clock: predict outputs from the pre-edge state, advance the model,
   // then compare after the edge.
   task automatic cycle();
      int         slot, dig;
      logic [5:0] es;
      logic [7:0] em;
      logic       ef;
      slot = m_pos % DIG;
      dig  = m_pos / DIG;
      es = 6'h3f;
      em = 8'hff;
      ef = 1'b0;
      if (!rst) begin
         if (slot >= BLK) begin
            es = ~(6'b1 << dig);
            em = exp_ment(dig, u_if.lzb);
         end
         ef = (m_pos == FRAME - 1);
      end
      if (rst) begin
         for (int d = 0; d < 6; d++) begin
            m_sh_val[d] = 0; m_sh_dp[d] = 0; m_ac_val[d] = 0; m_ac_dp[d] = 0;
         end
         m_pend = 0;
         m_pos  = 0;
      end else begin
         if (u_if.wr_vld && !m_pend && u_if.wr_addr < 3'd6) begin
            m_sh_val[u_if.wr_addr] = u_if.wr_data;
            m_sh_dp[u_if.wr_addr]  = u_if.wr_dp;
         end
         if (m_pos == FRAME - 1 && m_pend) begin
            for (int d = 0; d < 6; d++) begin
               m_ac_val[d] = m_sh_val[d]; m_ac_dp[d] = m_sh_dp[d];
            end
            m_pend = 0;
         end else if (u_if.commit) begin
            m_pend = 1;
         end
         m_pos = (m_pos + 1) % FRAME;
      end
      @(posedge clk);
      #1;
      chk("seg_sel",     {2'b0, u_if.seg_sel},     {2'b0, es});
      chk("seg_ment",    u_if.seg_ment,            em);
      chk("frame_done",  {7'b0, u_if.frame_done},  {7'b0, ef});
      chk("commit_pend", {7'b0, u_if.commit_pend}, {7'b0, m_pend});
      chk("wr_rdy",      {7'b0, u_if.wr_rdy},      {7'b0, !m_pend});
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic run_to(input int pos);
      while (m_pos != pos) cycle();
   endtask

   task automatic wr(input logic [2:0] a, input logic [3:0] v, input logic dp);
      u_if.wr_vld  = 1'b1;
      u_if.wr_addr = a;
      u_if.wr_data = v;
      u_if.wr_dp   = dp;
      cycle();
      u_if.wr_vld  = 1'b0;
   endtask

   task automatic do_commit();
      u_if.commit = 1'b1;
      cycle();
      u_if.commit = 1'b0;
   endtask

   initial begin
      u_if.wr_vld  = 1'b0;
      u_if.wr_addr = 3'd0;
      u_if.wr_data = 4'd0;
      u_if.wr_dp   = 1'b0;
      u_if.commit  = 1'b0;
      u_if.lzb     = 1'b0;
      m_pend = 0;
      m_pos  = 0;

      // Reset and first digit slot timing
      rst = 1'b1;
      idle(2);
      rst = 1'b0;
      idle(2);
      chk("cyc2_sel", {2'b0, u_if.seg_sel}, 8'h3f);
      cycle();
      chk("cyc3_sel",  {2'b0, u_if.seg_sel}, 8'h3e);
      chk("cyc3_ment", u_if.seg_ment, 8'hc0);
      idle(FRAME - 3);

      // Shadow writes stay invisible without a commit
      wr(3'd0, 4'h7, 1'b0);
      wr(3'd3, 4'hA, 1'b1);
      idle(3 * FRAME);

      // Mid-frame commit publishes at the next boundary
      run_to(20);
      do_commit();
      chk("pend_after_commit", {7'b0, u_if.commit_pend}, 8'h01);
      run_to(0);
      idle(FRAME);

      // Leading-zero blanking with bank {0,0,0,3,0,0}
      wr(3'd0, 4'h0, 1'b0);
      wr(3'd3, 4'h0, 1'b0);
      wr(3'd2, 4'h3, 1'b0);
      do_commit();
      run_to(0);
      u_if.lzb = 1'b1;
      idle(FRAME);
      u_if.lzb = 1'b0;
      idle(FRAME);

      // Commit landing exactly on the boundary waits a whole frame
      wr(3'd5, 4'h9, 1'b1);
      run_to(FRAME - 1);
      do_commit();
      idle(2 * FRAME);

      // Out-of-range address is dropped; reset mid-show discards pending commit
      wr(3'd6, 4'hF, 1'b1);
      idle(FRAME);
      wr(3'd0, 4'h5, 1'b0);
      do_commit();
      run_to(DIG + BLK + 2);
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      chk("rst_sel",  {2'b0, u_if.seg_sel}, 8'h3f);
      chk("rst_ment", u_if.seg_ment, 8'hff);
      chk("rst_pend", {7'b0, u_if.commit_pend}, 8'h00);
      idle(FRAME);

      // Random traffic
      for (int i = 0; i < 1500; i++) begin
         u_if.wr_vld  = ($urandom_range(0, 2) == 0);
         u_if.wr_addr = 3'($urandom_range(0, 7));
         u_if.wr_data = 4'($urandom_range(0, 15));
         u_if.wr_dp   = ($urandom_range(0, 3) == 0);
         u_if.commit  = ($urandom_range(0, 29) == 0);
         if ($urandom_range(0, 99) == 0) u_if.lzb = ~u_if.lzb;
         rst = ($urandom_range(0, 499) == 0);
         cycle();
      end
      rst = 1'b0;
      u_if.wr_vld = 1'b0;
      u_if.commit = 1'b0;
      idle(FRAME);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
